// File: rtl/pacman_move_ctrl_if.sv
// Signal bundle between the Pac-Man movement controller and the maze/player environment.
// master = movement controller, slave = environment (player input plus maze lookup).
interface pacman_move_ctrl_if;
  logic       freeze;
  logic [3:0] req_dir;
  logic [3:0] legal_moves;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic [3:0] current_direction;
  logic [2:0] tile_row;
  logic [2:0] tile_col;
  logic       query;
  logic       moving;
  logic [1:0] dbg_state;

  modport master (
    input  freeze, req_dir, legal_moves,
    output xpos, ypos, current_direction, tile_row, tile_col, query, moving, dbg_state
  );

  modport slave (
    output freeze, req_dir, legal_moves,
    input  xpos, ypos, current_direction, tile_row, tile_col, query, moving, dbg_state
  );
endinterface

// File: rtl/pacman_move_ctrl.sv
// Tile-by-tile sprite movement on an 8x8 maze: query the tile, choose a direction,
// then glide one tile in STEP_PX increments on each move tick.
module pacman_move_ctrl #(
  parameter logic [2:0] START_COL = 3'd0,
  parameter logic [2:0] START_ROW = 3'd0,
  parameter int         STEP_PX   = 2,
  parameter int         TICK_DIV  = 833333
) (
  input  logic                clk,
  input  logic                reset,
  pacman_move_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    QUERY  = 2'd0,
    DECIDE = 2'd1,
    MOVE   = 2'd2
  } state_e;

  localparam int              CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   TICK_MAX = CW'(TICK_DIV - 1);
  localparam logic [9:0]      X0       = 10'(150 + 60 * START_COL);
  localparam logic [9:0]      Y0       = 10'(34 + 60 * START_ROW);
  localparam logic [9:0]      STEP10   = 10'(STEP_PX);
  localparam logic [6:0]      STEP7    = 7'(STEP_PX);

  state_e        state_q, state_d;
  logic          started_q, started_d;
  logic [3:0]    dir_q, dir_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [2:0]    col_q, col_d, row_q, row_d;
  logic [5:0]    off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          tick;
  logic [3:0]    legal_eff;
  logic [6:0]    off_sum;

  assign tick      = !bus.freeze && (cnt_q == TICK_MAX);
  assign cnt_d     = bus.freeze ? cnt_q : ((cnt_q == TICK_MAX) ? '0 : cnt_q + 1'b1);
  assign off_sum   = {1'b0, off_q} + STEP7;
  // Edge-of-maze moves are never legal, whatever the maze lookup says.
  assign legal_eff = bus.legal_moves &
                     {col_q != 3'd0, col_q != 3'd7, row_q != 3'd0, row_q != 3'd7};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= QUERY;
      started_q <= 1'b0;
      dir_q     <= 4'd0;
      x_q       <= X0;
      y_q       <= Y0;
      col_q     <= START_COL;
      row_q     <= START_ROW;
      off_q     <= 6'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      row_q     <= row_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    started_d = started_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    col_d     = col_q;
    row_d     = row_q;
    off_d     = off_q;
    case (state_q)
      // The first cycle out of reset only arms the strobe; the query pulse itself
      // always runs to completion, even under freeze.
      QUERY: begin
        if (!started_q) started_d = 1'b1;
        else            state_d   = DECIDE;
      end
      DECIDE: begin
        if (!bus.freeze) begin
          if ($onehot(bus.req_dir) && |(bus.req_dir & legal_eff)) dir_d = bus.req_dir;
          else if (!(|(dir_q & legal_eff)))                          dir_d = 4'd0;
          if (dir_d != 4'd0) state_d = MOVE;
        end
      end
      MOVE: begin
        if (tick) begin
          if (dir_q[3]) x_d = x_q - STEP10;
          if (dir_q[2]) x_d = x_q + STEP10;
          if (dir_q[1]) y_d = y_q - STEP10;
          if (dir_q[0]) y_d = y_q + STEP10;
          if (off_sum == 7'd60) begin
            off_d   = 6'd0;
            state_d = QUERY;
            if (dir_q[3]) col_d = col_q - 3'd1;
            if (dir_q[2]) col_d = col_q + 3'd1;
            if (dir_q[1]) row_d = row_q - 3'd1;
            if (dir_q[0]) row_d = row_q + 3'd1;
          end else begin
            off_d = off_sum[5:0];
          end
        end
      end
      default: state_d = QUERY;
    endcase
  end

  // legal_moves answers the tile presented during the query pulse and is read
  // on the following (DECIDE) cycle; tile_row/tile_col hold across both.
  assign bus.xpos              = x_q;
  assign bus.ypos              = y_q;
  assign bus.current_direction = dir_q;
  assign bus.tile_row          = row_q;
  assign bus.tile_col          = col_q;
  assign bus.query             = (state_q == QUERY) && started_q;
  assign bus.moving            = (state_q == MOVE);
  assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Bench for pacman_move_ctrl: directed scenarios plus random play, all compared
// every cycle against a tile/offset reference model.
module tb_pacman_move_ctrl;
  localparam int         TICK_DIV  = 4;
  localparam int         STEP_PX   = 20;
  localparam logic [2:0] START_COL = 3'd1;
  localparam logic [2:0] START_ROW = 3'd1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pacman_move_ctrl_if bus();

  pacman_move_ctrl #(
    .START_COL (START_COL),
    .START_ROW (START_ROW),
    .STEP_PX   (STEP_PX),
    .TICK_DIV  (TICK_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position is tile * 60 plus a signed offset along the heading.
  int         m_col, m_row, m_off, m_cnt;
  logic [3:0] m_dir;
  bit         m_pre, m_q, m_dec, m_mov;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_x();
    return 150 + 60 * m_col + (m_dir[2] ? m_off : 0) - (m_dir[3] ? m_off : 0);
  endfunction

  function automatic int model_y();
    return 34 + 60 * m_row + (m_dir[0] ? m_off : 0) - (m_dir[1] ? m_off : 0);
  endfunction

  task automatic model_reset();
    m_col = START_COL; m_row = START_ROW; m_off = 0; m_cnt = 0;
    m_dir = 4'd0; m_pre = 1; m_q = 0; m_dec = 0; m_mov = 0;
  endtask

  task automatic model_edge(input bit f, input logic [3:0] r, input logic [3:0] l);
    logic [3:0] eff;
    bit         tick;
    tick = (m_cnt == TICK_DIV - 1) && !f;
    if (!f) m_cnt = (m_cnt + 1) % TICK_DIV;
    if (m_pre) begin
      m_pre = 0; m_q = 1;
    end else if (m_q) begin
      m_q = 0; m_dec = 1;
    end else if (m_dec) begin
      if (!f) begin
        eff = l & {m_col > 0, m_col < 7, m_row > 0, m_row < 7};
        if ($countones(r) == 1 && (r & eff) != 0) m_dir = r;
        else if ((m_dir & eff) == 0)              m_dir = 4'd0;
        if (m_dir != 0) begin m_dec = 0; m_mov = 1; end
      end
    end else if (m_mov && tick) begin
      m_off += STEP_PX;
      if (m_off == 60) begin
        m_col += (m_dir[2] ? 1 : 0) - (m_dir[3] ? 1 : 0);
        m_row += (m_dir[0] ? 1 : 0) - (m_dir[1] ? 1 : 0);
        m_off = 0; m_mov = 0; m_q = 1;
      end
    end
  endtask

  task automatic compare_all();
    check_val("xpos",   32'(bus.xpos),              32'(model_x()));
    check_val("ypos",   32'(bus.ypos),              32'(model_y()));
    check_val("dir",    32'(bus.current_direction), 32'(m_dir));
    check_val("col",    32'(bus.tile_col),          32'(m_col));
    check_val("row",    32'(bus.tile_row),          32'(m_row));
    check_val("query",  32'(bus.query),             32'(m_q));
    check_val("moving", 32'(bus.moving),            32'(m_mov));
  endtask

  // Called at a falling edge: drive, clock, advance the model, then check.
  task automatic step(input bit f, input logic [3:0] r, input logic [3:0] l);
    bus.freeze = f; bus.req_dir = r; bus.legal_moves = l;
    @(posedge clk);
    model_edge(f, r, l);
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset between clock edges and checks the effect before any edge arrives.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_val("rst_x",   32'(bus.xpos), 32'd210);
    check_val("rst_y",   32'(bus.ypos), 32'd94);
    check_val("rst_dir", 32'(bus.current_direction), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         hit;
    logic [3:0] r;
    reset = 1'b0;
    bus.freeze = 1'b0; bus.req_dir = 4'd0; bus.legal_moves = 4'd0;
    do_reset();

    // Move right one tile from (1,1).
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(0, 4'b0100, 4'b0100);
      hit = (bus.query === 1'b1) && (bus.tile_col == 3'd2);
    end
    check_val("arrive_col2", 32'(hit), 32'd1);
    check_val("arrive_x270", 32'(bus.xpos), 32'd270);

    // Illegal left request while heading right keeps going right.
    step(0, 4'b1000, 4'b0101);
    step(0, 4'b1000, 4'b0101);
    check_val("reject_dir", 32'(bus.current_direction), 32'b0100);
    check_val("reject_mov", 32'(bus.moving), 32'd1);

    // Dead end at col 3, then turn down when it opens.
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(0, 4'b0000, 4'b0100);
      hit = (bus.query === 1'b1) && (bus.tile_col == 3'd3);
    end
    check_val("arrive_col3", 32'(hit), 32'd1);
    for (int i = 0; i < 5; i++) step(0, 4'b0000, 4'b0000);
    check_val("stop_dir", 32'(bus.current_direction), 32'd0);
    check_val("stop_mov", 32'(bus.moving), 32'd0);
    check_val("stop_x",   32'(bus.xpos), 32'd330);
    step(0, 4'b0001, 4'b0001);
    check_val("turn_dir", 32'(bus.current_direction), 32'b0001);
    check_val("turn_mov", 32'(bus.moving), 32'd1);
    for (int i = 0; i < 14; i++) step(0, 4'b0001, 4'b0001);

    // Bounds guard at column 0.
    do_reset();
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(0, 4'b1000, 4'b1000);
      hit = (bus.query === 1'b1) && (bus.tile_col == 3'd0);
    end
    check_val("arrive_col0", 32'(hit), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 4'b1000, 4'b1000);
    check_val("bound_dir", 32'(bus.current_direction), 32'd0);
    check_val("bound_x",   32'(bus.xpos), 32'd150);
    check_val("bound_mov", 32'(bus.moving), 32'd0);

    // Reset mid-move abandons the partial step.
    do_reset();
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(0, 4'b0100, 4'b0100);
      hit = (bus.xpos == 10'd230);
    end
    check_val("mid_x230", 32'(hit), 32'd1);
    do_reset();

    // Freeze mid-move, then resume from the same offset.
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(0, 4'b0100, 4'b0100);
      hit = (bus.xpos == 10'd230);
    end
    check_val("frz_pre", 32'(hit), 32'd1);
    for (int i = 0; i < 10; i++) step(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    check_val("frz_x",   32'(bus.xpos), 32'd230);
    check_val("frz_mov", 32'(bus.moving), 32'd1);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(0, 4'b0100, 4'b0100);
      hit = (bus.query === 1'b1) && (bus.tile_col == 3'd2);
    end
    check_val("frz_resume", 32'(hit), 32'd1);

    // Random play.
    do_reset();
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 1) == 1) r = 4'b0001 << $urandom_range(0, 3);
      else                           r = 4'($urandom_range(0, 15));
      step($urandom_range(0, 7) == 0, r, 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
